// File: rtl/wb_stage_if.sv
// Writeback stage port bundle: MEM result, multdiv completions and the register file write port.
// The forwarding compare signals exist only when WB_STAGE_FWD_EN is defined.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ovf;
  logic [31:0] mem_exc_code;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        stall_req;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
`ifdef WB_STAGE_FWD_EN
  logic [4:0]  fwd_rsA;
  logic [4:0]  fwd_rsB;
  logic        fwd_hitA;
  logic        fwd_hitB;
  logic [31:0] fwd_dataA;
  logic [31:0] fwd_dataB;

  modport master (
    output mem_valid, mem_we, mem_rd, mem_data, mem_ovf, mem_exc_code,
    output md_valid, md_rd, md_data, fwd_rsA, fwd_rsB,
    input  md_ready, stall_req, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB
  );
  modport slave (
    input  mem_valid, mem_we, mem_rd, mem_data, mem_ovf, mem_exc_code,
    input  md_valid, md_rd, md_data, fwd_rsA, fwd_rsB,
    output md_ready, stall_req, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB
  );
`else
  modport master (
    output mem_valid, mem_we, mem_rd, mem_data, mem_ovf, mem_exc_code,
    output md_valid, md_rd, md_data,
    input  md_ready, stall_req, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
  modport slave (
    input  mem_valid, mem_we, mem_rd, mem_data, mem_ovf, mem_exc_code,
    input  md_valid, md_rd, md_data,
    output md_ready, stall_req, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
`endif
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: merges MEM results and queued multdiv completions onto the regfile write port, 1-cycle latency.
// md_ready drops and stall_req rises while the multdiv FIFO is full; WB_STAGE_FWD_EN adds decode forwarding.
module wb_stage #(
  parameter int         MD_DEPTH   = 2,
  parameter logic [4:0] STATUS_REG = 5'd30
) (
  input logic       clock,
  input logic       ctrl_reset,
  wb_stage_if.slave bus
);
  localparam int PTRW = $clog2(MD_DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [4:0]          fifoRd   [MD_DEPTH];
  logic [31:0]         fifoData [MD_DEPTH];
  logic [MD_DEPTH-1:0] fifoVld;
  logic [PTRW-1:0]     rdPtr;
  logic [PTRW-1:0]     wrPtr;
  logic [CNTW-1:0]     count;

  logic        pipeWr;
  logic [4:0]  pipeRd;
  logic [31:0] pipeData;
  logic        fifoFull;
  logic        mdPush;
  logic        mdStore;
  logic        fifoPop;

  logic        weQ;
  logic [4:0]  regQ;
  logic [31:0] dataQ;

  always_comb begin
    pipeWr   = bus.mem_valid & (bus.mem_ovf | (bus.mem_we & (bus.mem_rd != 5'd0)));
    pipeRd   = bus.mem_ovf ? STATUS_REG : bus.mem_rd;
    pipeData = bus.mem_ovf ? bus.mem_exc_code : bus.mem_data;
  end

  assign fifoFull      = (count == CNTW'(MD_DEPTH));
  assign bus.md_ready  = ~fifoFull;
  assign bus.stall_req = fifoFull;

  // Results for r0, or for the register the pipe is writing right now, are accepted but never queued.
  assign mdPush  = bus.md_valid & ~fifoFull;
  assign mdStore = mdPush & (bus.md_rd != 5'd0) & ~(pipeWr & (bus.md_rd == pipeRd));
  assign fifoPop = ~pipeWr & (count != CNTW'(0));

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      weQ     <= 1'b0;
      regQ    <= 5'd0;
      dataQ   <= 32'd0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      fifoVld <= '0;
      for (int i = 0; i < MD_DEPTH; i++) begin
        fifoRd[i]   <= 5'd0;
        fifoData[i] <= 32'd0;
      end
    end else begin
      if (pipeWr) begin
        weQ   <= 1'b1;
        regQ  <= pipeRd;
        dataQ <= pipeData;
      end else if (fifoPop && fifoVld[rdPtr]) begin
        weQ   <= 1'b1;
        regQ  <= fifoRd[rdPtr];
        dataQ <= fifoData[rdPtr];
      end else begin
        weQ   <= 1'b0;
      end

      // A younger pipe write makes any queued result for the same register stale.
      for (int i = 0; i < MD_DEPTH; i++) begin
        if (pipeWr && (fifoRd[i] == pipeRd)) begin
          fifoVld[i] <= 1'b0;
        end
      end

      if (fifoPop) begin
        fifoVld[rdPtr] <= 1'b0;
        rdPtr          <= rdPtr + 1'b1;
      end

      if (mdStore) begin
        fifoRd[wrPtr]   <= bus.md_rd;
        fifoData[wrPtr] <= bus.md_data;
        fifoVld[wrPtr]  <= 1'b1;
        wrPtr           <= wrPtr + 1'b1;
      end

      count <= count + CNTW'(mdStore) - CNTW'(fifoPop);
    end
  end

  assign bus.ctrl_writeEnable = weQ;
  assign bus.ctrl_writeReg    = regQ;
  assign bus.data_writeReg    = dataQ;

`ifdef WB_STAGE_FWD_EN
  logic hitA;
  logic hitB;

  assign hitA          = weQ & (regQ == bus.fwd_rsA) & (bus.fwd_rsA != 5'd0);
  assign hitB          = weQ & (regQ == bus.fwd_rsB) & (bus.fwd_rsB != 5'd0);
  assign bus.fwd_hitA  = hitA;
  assign bus.fwd_hitB  = hitB;
  assign bus.fwd_dataA = hitA ? dataQ : 32'd0;
  assign bus.fwd_dataB = hitB ? dataQ : 32'd0;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage sitting directly upstream of the register file.
- Registers the MEM-stage result and merges it with late multiply/divide completions, which are held in a small FIFO.
- Substitutes the overflow status write to $r30 when an exception is flagged.
- Drives the register file write port: ctrl_writeEnable, ctrl_writeReg, data_writeReg. At most one write per cycle.

Parameters:
- MD_DEPTH, 2, number of pending multdiv results buffered (power of 2, ≥2).
- STATUS_REG, 30, register index written on overflow.

Ports:
- clock  in  1  system clock; all state updates on posedge
- ctrl_reset  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM stage holds a valid instruction this cycle
- mem_we  in  1  instruction writes a register
- mem_rd  in  5  destination register
- mem_data  in  32  result to write
- mem_ovf  in  1  overflow exception on this instruction
- mem_exc_code  in  32  value written to STATUS_REG on overflow
- md_valid  in  1  multdiv result offered
- md_rd  in  5  multdiv destination register
- md_data  in  32  multdiv result
- md_ready  out  1  FIFO can accept (= count<MD_DEPTH)
- stall_req  out  1  FIFO full; upstream must present mem_valid=0 next cycle
- ctrl_writeEnable  out  1  register file write enable
- ctrl_writeReg  out  5  register file write address
- data_writeReg  out  32  register file write data

Behaviour:
- Reset: synchronous; when ctrl_reset=1 at posedge, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, FIFO emptied, all entries invalid. md_ready=1 and stall_req=0 the cycle after reset. Reset mid-operation discards all pending multdiv results.
- Pipe write request (combinational): pw = mem_valid & (mem_ovf | (mem_we & mem_rd≠0)).
  - Target is STATUS_REG with mem_exc_code if mem_ovf=1.
  - Otherwise target is mem_rd with mem_data.
- Source priority each cycle: pipe write > FIFO head > none.
- Output registers load at posedge; latency is exactly 1 cycle from input to write-port outputs.
- No write: ctrl_writeEnable=0; ctrl_writeReg and data_writeReg hold their previous values.
- Output never presents ctrl_writeReg=0 with ctrl_writeEnable=1.
- FIFO push: md_valid & md_ready.
  - md_rd=0: accepted but not stored.
  - md_rd equal to the target of a simultaneous pw: accepted and dropped (younger pipe write wins).
  - Otherwise stored with valid=1.
- FIFO pop: occurs when pw=0 and FIFO non-empty.
  - Valid head: produces a write of its rd/data.
  - Invalid head: popped with ctrl_writeEnable=0.
- WAW kill: when pw is accepted, every FIFO entry whose rd equals the pw target is marked invalid at the same posedge.
- Simultaneous push and pop: both occur; count unchanged. A push into a full FIFO is impossible because md_ready=0.
- Count arithmetic: count is log2(MD_DEPTH)+1 bits. Read/write pointers wrap modulo MD_DEPTH.
- stall_req = (count==MD_DEPTH). Upstream contract: mem_valid=0 in the following cycle, which guarantees a pop. If mem_valid=1 anyway, the pipe write still wins and the FIFO holds.
- Ordering: FIFO entries drain oldest-first.

Optional Feature:
- Macro: WB_STAGE_FWD_EN.
- When defined, adds:
  - inputs fwd_rsA[4:0] and fwd_rsB[4:0]
  - outputs fwd_hitA, fwd_hitB (1 bit each) and fwd_dataA, fwd_dataB (32 bits each)
- Forwarding behaviour (combinational):
  - fwd_hitX = ctrl_writeEnable & (ctrl_writeReg==fwd_rsX) & (fwd_rsX≠0).
  - fwd_dataX = data_writeReg when hit, else 0.
  - This lets decode bypass the register file's write/read ordering.
- When not defined, these ports do not exist and no compare logic is built.

Test Plan:
- Reset, then mem_valid=1, mem_we=1, mem_rd=5, mem_data=0xDEADBEEF -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF. A pipe write with mem_rd=0 -> ctrl_writeEnable=0.
- mem_ovf=1, mem_rd=7, mem_exc_code=1 -> ctrl_writeReg=30, data_writeReg=1; register 7 is not written.
- Push md results rd=3 (0x11), then rd=4 (0x22) while pipe writes every cycle -> md_ready=0 and stall_req=1 after the second push. Then a mem_valid=0 bubble -> writes rd=3 then rd=4 on successive idle cycles; md_ready returns to 1.
- Queue md rd=9, then pipe writes rd=9 before the FIFO drains -> entry invalidated; when it drains, no write occurs to rd=9 from the FIFO; the last rd=9 write observed is the pipe's.
- Assert ctrl_reset with 2 FIFO entries pending -> outputs 0, md_ready=1; no queued writes ever appear afterwards.
- (WB_STAGE_FWD_EN) Write rd=12 = 0xCAFE with fwd_rsA=12 and fwd_rsB=0 -> fwd_hitA=1, fwd_dataA=0xCAFE, fwd_hitB=0.
